// File: rtl/uart_data_rx.sv
// Multi-byte UART receiver: assembles NBYTES 8N1 frames into one DATA_WIDTH word.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_data_rx #(
  parameter int DATA_WIDTH   = 56,
  parameter bit MSB_FIRST    = 1'b1,
  parameter int CLK_FREQ     = 50000000,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [2:0]            Baud_Set,
  input  logic                  uart_rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  Rx_Done,
  output logic                  uart_state,
  output logic                  Frame_Err,
  output logic                  Parity_Err
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DIV_W  = $clog2(CLK_FREQ / 9600 + 1);
  localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(CLK_FREQ / 9600);
  localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(CLK_FREQ / 19200);
  localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(CLK_FREQ / 38400);
  localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(CLK_FREQ / 57600);
  localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(CLK_FREQ / 115200);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NBYTES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
    case (sel)
      3'd1:    return DIV_19200;
      3'd2:    return DIV_38400;
      3'd3:    return DIV_57600;
      3'd4:    return DIV_115200;
      default: return DIV_9600;
    endcase
  endfunction

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  state_t                r_state;
  logic                  r_rx_meta;
  logic                  r_rx_sync;
  logic                  r_rx_prev;
  logic [DIV_W-1:0]      r_cnt;
  logic [DIV_W-1:0]      r_div;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_shift;
  logic [BCNT_W-1:0]     r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_asm;
  logic                  r_load;
  logic [TMO_W-1:0]      r_tmo_bits;

  logic                  w_fall;
  logic                  w_bit_end;
  logic                  w_half_end;
  logic [BCNT_W-1:0]     w_lane;
  logic                  w_par_drop;

  assign w_fall     = r_rx_prev & ~r_rx_sync;
  assign w_bit_end  = (r_cnt == (r_div - DIV_W'(1)));
  assign w_half_end = (r_cnt == ((r_div >> 1) - DIV_W'(1)));
  assign w_lane     = MSB_FIRST ? (LAST_BYTE - r_byte_cnt) : r_byte_cnt;

  // Two-flop synchroniser plus edge-detect history for the serial line
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  assign w_par_drop = r_par_bad;
`else
  assign w_par_drop = 1'b0;
  assign Parity_Err = 1'b0;
`endif

  // Receive FSM: bit timing, byte assembly, word hand-off and inter-byte timeout
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_div      <= DIV_9600;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_load     <= 1'b0;
      r_tmo_bits <= '0;
      data       <= '0;
      Rx_Done    <= 1'b0;
      uart_state <= 1'b0;
      Frame_Err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= 1'b0;
      Parity_Err <= 1'b0;
`endif
    end else begin
      Rx_Done   <= 1'b0;
      Frame_Err <= 1'b0;
      r_load    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      Parity_Err <= 1'b0;
`endif
      if (r_load) begin
        data       <= r_asm;
        Rx_Done    <= 1'b1;
        uart_state <= 1'b0;
      end else begin
        data <= data;
      end

      case (r_state)
        S_IDLE: begin
          // A start edge takes priority over a timeout expiring in the same clock
          if (w_fall) begin
            r_state    <= S_START;
            uart_state <= 1'b1;
            r_div      <= baud_div(Baud_Set);
            r_cnt      <= '0;
            r_tmo_bits <= '0;
          end else if (r_byte_cnt != '0) begin
            if (w_bit_end) begin
              r_cnt <= '0;
              if (r_tmo_bits == TMO_LAST) begin
                r_byte_cnt <= '0;
                r_tmo_bits <= '0;
                r_asm      <= '0;
                uart_state <= 1'b0;
              end else begin
                r_tmo_bits <= r_tmo_bits + TMO_W'(1);
              end
            end else begin
              r_cnt <= r_cnt + DIV_W'(1);
            end
          end else begin
            r_cnt      <= '0;
            r_tmo_bits <= '0;
          end
        end

        S_START: begin
          if (w_half_end) begin
            r_cnt <= '0;
            if (r_rx_sync) begin
              r_state <= S_IDLE;
              if (r_byte_cnt == '0) begin
                uart_state <= 1'b0;
              end else begin
                uart_state <= uart_state;
              end
            end else begin
              r_state   <= S_DATA;
              r_bit_idx <= 3'd0;
            end
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt      <= '0;
            r_par_bad  <= (r_rx_sync != even_parity(r_shift));
            Parity_Err <= (r_rx_sync != even_parity(r_shift));
            r_state    <= S_STOP;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
`endif

        S_STOP: begin
          // Decide at mid-stop so a back-to-back start edge is still seen in IDLE
          if (w_bit_end) begin
            r_cnt      <= '0;
            r_tmo_bits <= '0;
            r_state    <= S_IDLE;
            if (!r_rx_sync || w_par_drop) begin
              Frame_Err  <= ~r_rx_sync;
              r_byte_cnt <= '0;
              r_asm      <= '0;
              uart_state <= 1'b0;
            end else begin
              r_asm[{w_lane, 3'b000} +: 8] <= r_shift;
              if (r_byte_cnt == LAST_BYTE) begin
                r_byte_cnt <= '0;
                r_load     <= 1'b1;
              end else begin
                r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
              end
            end
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_byte_cnt <= '0;
          uart_state <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_data_rx.sv
// Scoreboard bench for uart_data_rx: one MSB_FIRST and one LSB-first instance share the line.
module tb_uart_data_rx;

  localparam int CLK_FREQ = 1152000;  // gives 120/60/30/20/10 clocks per bit
  localparam logic [55:0] W1   = 56'h01234567012345;
  localparam logic [55:0] W1_L = 56'h45230167452301;
  localparam logic [55:0] W2   = 56'h89ABCDEF103254;
  localparam logic [55:0] W2_L = 56'h543210EFCDAB89;
  localparam logic [55:0] W3   = 56'h12345678123456;
  localparam logic [55:0] W3_L = 56'h56341278563412;
  localparam logic [55:0] W4   = 56'h23456789234567;
  localparam logic [55:0] W4_L = 56'h67452389674523;
  localparam logic [55:0] WX   = 56'hAABBCC00000000;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [2:0]  Baud_Set = 3'd4;
  logic        uart_rx = 1'b1;
  logic [55:0] data_m, data_l;
  logic        done_m, done_l, st_m, st_l, ferr_m, ferr_l, perr_m, perr_l;

  int total = 0;
  int bad = 0;
  int exp_ferr = 0;
  int got_ferr_m = 0;
  int got_ferr_l = 0;
  logic perr_seen = 1'b0;
  logic prev_done_m = 1'b0, prev_done_l = 1'b0, prev_st_m = 1'b0, prev_st_l = 1'b0;
  logic [55:0] q_m[$];
  logic [55:0] q_l[$];

  uart_data_rx #(.DATA_WIDTH(56), .MSB_FIRST(1'b1), .CLK_FREQ(CLK_FREQ), .TIMEOUT_BITS(20)) u_dut_m (
    .Clk(Clk), .Rst_n(Rst_n), .Baud_Set(Baud_Set), .uart_rx(uart_rx),
    .data(data_m), .Rx_Done(done_m), .uart_state(st_m), .Frame_Err(ferr_m), .Parity_Err(perr_m));

  uart_data_rx #(.DATA_WIDTH(56), .MSB_FIRST(1'b0), .CLK_FREQ(CLK_FREQ), .TIMEOUT_BITS(20)) u_dut_l (
    .Clk(Clk), .Rst_n(Rst_n), .Baud_Set(Baud_Set), .uart_rx(uart_rx),
    .data(data_l), .Rx_Done(done_l), .uart_state(st_l), .Frame_Err(ferr_l), .Parity_Err(perr_l));

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected word whenever a DUT signals Rx_Done
  always @(negedge Clk) begin
    if (done_m) begin
      check("done_width_m", {63'd0, prev_done_m}, 64'd0);
      check("state_before_done_m", {63'd0, prev_st_m}, 64'd1);
      check("state_at_done_m", {63'd0, st_m}, 64'd0);
      if (q_m.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done_m: got data %h expected no word", data_m);
      end else begin
        check("data_m", {8'd0, data_m}, {8'd0, q_m.pop_front()});
      end
    end
    if (done_l) begin
      check("done_width_l", {63'd0, prev_done_l}, 64'd0);
      check("state_before_done_l", {63'd0, prev_st_l}, 64'd1);
      check("state_at_done_l", {63'd0, st_l}, 64'd0);
      if (q_l.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done_l: got data %h expected no word", data_l);
      end else begin
        check("data_l", {8'd0, data_l}, {8'd0, q_l.pop_front()});
      end
    end
    if (ferr_m) got_ferr_m <= got_ferr_m + 1;
    if (ferr_l) got_ferr_l <= got_ferr_l + 1;
    perr_seen   <= perr_seen | perr_m | perr_l;
    prev_done_m <= done_m;
    prev_done_l <= done_l;
    prev_st_m   <= st_m;
    prev_st_l   <= st_l;
  end

  // Called at a negedge; returns at a negedge with the line idle
  task automatic send_byte(input logic [7:0] b, input logic stop, input int div);
    uart_rx = 1'b0;
    repeat (div) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (div) @(negedge Clk);
    end
    uart_rx = stop;
    repeat (div) @(negedge Clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [55:0] w, input int div, input int nbytes, input int bad_idx);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(w[55-8*i -: 8], (i != bad_idx), div);
    end
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check("rst_data_m", {8'd0, data_m}, 64'd0);
    check("rst_data_l", {8'd0, data_l}, 64'd0);
    check("rst_done", {62'd0, done_m, done_l}, 64'd0);
    check("rst_state", {62'd0, st_m, st_l}, 64'd0);
    check("rst_ferr", {62'd0, ferr_m, ferr_l}, 64'd0);
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);

    // Back-to-back word at 10 clocks per bit
    q_m.push_back(W1);
    q_l.push_back(W1_L);
    send_word(W1, 10, 7, -1);
    repeat (20) @(negedge Clk);

    // Short glitch must be rejected as a false start
    uart_rx = 1'b0;
    repeat (3) @(negedge Clk);
    uart_rx = 1'b1;
    repeat (6) @(negedge Clk);
    check("glitch_state", {62'd0, st_m, st_l}, 64'd0);
    repeat (20) @(negedge Clk);

    // Bad stop bit on the third byte, then a clean word
    exp_ferr++;
    send_word(W2, 10, 3, 2);
    repeat (20) @(negedge Clk);
    check("ferr_count_m", 64'(got_ferr_m), 64'(exp_ferr));
    check("ferr_data_kept_m", {8'd0, data_m}, {8'd0, W1});
    check("ferr_data_kept_l", {8'd0, data_l}, {8'd0, W1_L});
    check("ferr_state", {62'd0, st_m, st_l}, 64'd0);
    q_m.push_back(W2);
    q_l.push_back(W2_L);
    send_word(W2, 10, 7, -1);
    repeat (20) @(negedge Clk);

    // Partial word abandoned by the inter-byte timeout
    send_word(WX, 10, 3, -1);
    check("tmo_state_pending", {62'd0, st_m, st_l}, 64'd3);
    repeat (210) @(negedge Clk);
    check("tmo_state_dropped", {62'd0, st_m, st_l}, 64'd0);
    q_m.push_back(W3);
    q_l.push_back(W3_L);
    send_word(W3, 10, 7, -1);
    repeat (20) @(negedge Clk);

    // Slowest baud
    Baud_Set = 3'd0;
    q_m.push_back(W4);
    q_l.push_back(W4_L);
    send_word(W4, 120, 7, -1);
    repeat (200) @(negedge Clk);

    // Reset asserted in the middle of the fourth byte
    send_word(W1, 120, 3, -1);
    uart_rx = 1'b0;
    repeat (400) @(negedge Clk);
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    check("midrst_data_m", {8'd0, data_m}, 64'd0);
    check("midrst_data_l", {8'd0, data_l}, 64'd0);
    check("midrst_state", {62'd0, st_m, st_l}, 64'd0);
    check("midrst_done", {62'd0, done_m, done_l}, 64'd0);
    uart_rx = 1'b1;
    repeat (5) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (1500) @(negedge Clk);

    check("words_left_m", 64'(q_m.size()), 64'd0);
    check("words_left_l", 64'(q_l.size()), 64'd0);
    check("ferr_total_m", 64'(got_ferr_m), 64'(exp_ferr));
    check("ferr_total_l", 64'(got_ferr_l), 64'(exp_ferr));
    check("parity_err_idle", {63'd0, perr_seen}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_data_rx.md
Name: uart_data_rx

Overview:
Multi-byte UART receiver, the counterpart of the team's multi-byte UART transmitter.
- Each UART byte frame is 8N1: one start bit, 8 data bits LSB first, one stop bit.
- Bytes are deserialised and assembled into one DATA_WIDTH-bit word.
- When the full word has arrived, the word is presented with a single-cycle Rx_Done pulse.
- Sits between the board RX pin and the command decoder. Shares the Baud_Set encoding and MSB_FIRST byte ordering with the transmitter.

Parameters:
- DATA_WIDTH, 56, word width in bits; must be a multiple of 8; NBYTES = DATA_WIDTH/8.
- MSB_FIRST, 1, 1: the first received byte lands in data[DATA_WIDTH-1:DATA_WIDTH-8]; 0: the first byte lands in data[7:0].
- CLK_FREQ, 50000000, Clk frequency in Hz; used to derive the baud dividers.
- TIMEOUT_BITS, 20, maximum idle gap between bytes of one word, counted in bit periods.

Ports:
- Clk, input, 1, system clock.
- Rst_n, input, 1, asynchronous active-low reset.
- Baud_Set, input, 3, baud select. 0 = 9600, 1 = 19200, 2 = 38400, 3 = 57600, 4 = 115200; 5 to 7 behave as 9600.
- uart_rx, input, 1, serial line; asynchronous to Clk; idles high.
- data, output, DATA_WIDTH, last completely received word.
- Rx_Done, output, 1, one-cycle pulse when data has been updated.
- uart_state, output, 1, high while a word is being received.
- Frame_Err, output, 1, one-cycle pulse on a bad stop bit.
- Parity_Err, output, 1, one-cycle pulse on a parity mismatch (see Optional Feature).

Behaviour:
- Reset: data = 0, Rx_Done = 0, uart_state = 0, Frame_Err = 0, Parity_Err = 0. Byte counter = 0, FSM = IDLE, synchroniser flops = 1. Reset is honoured mid-frame: the partial word is discarded and data returns to 0.
- Input path: uart_rx passes through a 2-flop synchroniser. A falling edge is detected on the synchronised signal.
- Bit period: BAUD_DIV = CLK_FREQ / baud, integer-truncated. At 50 MHz this gives 5208, 2604, 1302, 868 and 434 for Baud_Set 0 to 4.
- Baud_Set is sampled at each start-bit detection and held constant for that byte.
- FSM states: IDLE, START, DATA, STOP, plus PARITY when the optional feature is compiled in.
  - IDLE: a falling edge moves the FSM to START; uart_state goes high.
  - START: wait BAUD_DIV/2 clocks, then sample.
    - Sample 1 (false start): return to IDLE. Byte counter is untouched. uart_state drops only if the byte counter is 0.
    - Sample 0: go to DATA.
  - DATA: sample every BAUD_DIV clocks. 8 samples are shifted in LSB first, then go to STOP.
  - STOP: sample after BAUD_DIV clocks.
    - Sample 1: byte accepted.
    - Sample 0: Frame_Err pulses, the partial word is discarded, the byte counter resets to 0, uart_state drops, and the FSM returns to IDLE. data is unchanged.
- Byte accept:
  - The byte is written into the byte lane selected by the byte counter and MSB_FIRST.
  - The counter increments; the FSM returns to IDLE immediately, at mid-stop bit, so a back-to-back start edge is caught.
  - When the accepted byte is byte NBYTES-1: data is loaded from the assembly register in the next clock, Rx_Done pulses high in that same clock, the counter wraps to 0, and uart_state drops in that same clock.
  - Rx_Done is exactly one clock wide. data holds until the next complete word.
- Inter-byte timeout: applies in IDLE with byte counter > 0. If no start edge arrives within TIMEOUT_BITS × BAUD_DIV clocks, the partial word is discarded, the counter resets to 0 and uart_state drops. There is no error pulse and data is unchanged.
- Simultaneous events: a start edge in the same clock as the timeout expiry wins; the timeout is not taken.
- The assembly register is separate from data, so data never shows a partial word.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1; a PARITY state between DATA and STOP samples an even parity bit.
  - On mismatch, Parity_Err pulses one clock when the parity bit is sampled, the rest of the frame is still received, and then the word is discarded exactly as for a frame error. Frame_Err does not pulse.
- Undefined: frame is 8N1, no PARITY state exists, and Parity_Err is tied to 0.

Test Plan:
- Defaults, Baud_Set = 4: send bytes 01 23 45 67 01 23 45 back-to-back with 434-clock bits. Expect data = 56'h01234567012345, exactly one Rx_Done pulse, and uart_state high from the first start edge until the Rx_Done clock.
- MSB_FIRST = 0: send the same 7 bytes. Expect data = 56'h45230167452301.
- Glitches: a 3-clock low pulse on an idle line gives no Rx_Done, no Frame_Err, and uart_state back to 0 within BAUD_DIV/2 + 4 clocks. Separately, a stop bit forced to 0 on byte 3 gives one Frame_Err pulse; data keeps its prior value; a following clean 7-byte word is received correctly.
- Timeout: send 3 bytes, idle for 21 bit periods, then send 7 bytes 12 34 56 78 12 34 56. Expect data = 56'h12345678123456 with a single Rx_Done.
- Baud_Set = 0: the 7-byte word 23 45 67 89 23 45 67 sent at 5208 clocks/bit gives data = 56'h23456789234567. Asserting Rst_n = 0 during byte 4 of a later word clears all outputs to 0 and produces no Rx_Done.
- With UART_RX_PARITY_EN: a wrong parity bit on byte 2 gives one Parity_Err pulse, no Rx_Done, and uart_state = 0 after the stop bit.
